phdiff_monitor: RTL

Consumes the phase-difference and vernier-frequency words from the DMTD phase-difference stage in the readout clock domain. Samples them periodically, unwraps the modular phase difference, and produces a windowed average. A lock/fault state machine and slip counter sit on top for the local-bus register map. This is the last stage before software and replaces ad-hoc polling of raw, jittery phase words.

---
 rtl/phdiff_pkg.sv | 20 ++
 rtl/phdiff_wrapdiff.sv | 12 +
 rtl/phdiff_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/phdiff_pkg.sv
// Shared types and helpers for the DMTD phase-difference monitor.
package phdiff_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam int SLIP_W = 8;

  // A step is quiet when its magnitude is within tol; the most-negative code is ambiguous.
  function automatic logic is_quiet(input int step, input int pw, input int tol);
    int most_neg;
    most_neg = -(1 << (pw - 1));
    return (step != most_neg) && (step <= tol) && (step >= -tol);
  endfunction

endpackage

// File: rtl/phdiff_wrapdiff.sv
// Modular signed difference a - b of two w-bit wrapped phase words.
module phdiff_wrapdiff #(
  parameter int w = 13
) (
  input  logic        [w-1:0] a,
  input  logic        [w-1:0] b,
  output logic signed [w-1:0] d
);

  assign d = signed'(a - b);

endmodule

// File: rtl/phdiff_monitor.sv
// Periodic sampler, phase unwrap/window average and lock/fault tracking for DMTD phase words.
// Optional PHDIFF_MINMAX_EN adds per-window ph_min/ph_max outputs.
module phdiff_monitor
  import phdiff_pkg::*;
#(
  parameter int dw         = 14,
  parameter int sample_log = 6,
  parameter int avg_log    = 4,
  parameter int tol        = 8,
  parameter int lock_n     = 16
) (
  input  logic              rclk,
  input  logic              rst_n,
  input  logic [dw-2:0]     phdiff,
  input  logic [dw-1:0]     vfreq,
  input  logic              err_in,
  input  logic              clear,
  output logic [dw-2:0]     avg_out,
  output logic              avg_valid,
  output logic [dw-1:0]     vfreq_hold,
  output logic              locked,
  output logic              fault_sticky,
  output logic [SLIP_W-1:0] slips
`ifdef PHDIFF_MINMAX_EN
  ,
  output logic [dw-2:0]     ph_min,
  output logic [dw-2:0]     ph_max
`endif
);

  localparam int PW = dw - 1;
  localparam int SW = PW + avg_log;
  localparam int QW = $clog2(lock_n + 1);

  function automatic logic [SLIP_W-1:0] sat_inc(input logic [SLIP_W-1:0] v);
    return (&v) ? v : v + SLIP_W'(1);
  endfunction

  // Stage 0: free-running sample interval counter
  logic [sample_log-1:0] cnt_p0;
  logic                  tick_p0;
  assign tick_p0 = &cnt_p0;

  logic          vld_p1;
  logic          err_p1;
  logic [PW-1:0] ph_p1;
  logic [dw-1:0] vf_p1;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_p0 + sample_log'(1);
      vld_p1 <= tick_p0;
    end
  end

  // Stage 1: registered copies of the tracker words
  always_ff @(posedge rclk) begin
    if (tick_p0) begin
      ph_p1  <= phdiff;
      vf_p1  <= vfreq;
      err_p1 <= err_in;
    end
  end

  logic [PW-1:0]        ph_prev_p2;
  logic [PW-1:0]        base_p2;
  logic signed [SW-1:0] sum_p2;
  logic                 prev_ok_p2;
  logic [avg_log-1:0]   win_cnt_p2;
  state_t               state_p2;
  logic [QW-1:0]        qcnt_p2;

  logic signed [PW-1:0] step_p1;
  logic signed [PW-1:0] rel_raw_p1;
  logic signed [PW-1:0] rel_p1;
  logic signed [SW-1:0] sum_nxt_p1;
  logic [PW-1:0]        base_nxt_p1;
  logic [PW-1:0]        avg_nxt_p1;
  logic                 first_p1, last_p1, quiet_p1, fault_p1, slip_p1;

  phdiff_wrapdiff #(.w(PW)) u_step (.a(ph_p1), .b(ph_prev_p2), .d(step_p1));
  phdiff_wrapdiff #(.w(PW)) u_rel  (.a(ph_p1), .b(base_p2),    .d(rel_raw_p1));

  // Offsets from the window base keep the sum continuous across the phase wrap.
  always_comb begin
    first_p1    = (win_cnt_p2 == '0);
    last_p1     = &win_cnt_p2;
    rel_p1      = first_p1 ? '0 : rel_raw_p1;
    base_nxt_p1 = first_p1 ? ph_p1 : base_p2;
    sum_nxt_p1  = (first_p1 ? '0 : sum_p2) + {{avg_log{rel_p1[PW-1]}}, rel_p1};
    avg_nxt_p1  = base_nxt_p1 + sum_nxt_p1[SW-1:avg_log];
    quiet_p1    = prev_ok_p2 && is_quiet(int'(step_p1), PW, tol);
    fault_p1    = vld_p1 && err_p1;
    slip_p1     = vld_p1 && !err_p1 && (state_p2 == LOCKED) && !quiet_p1;
  end

`ifdef PHDIFF_MINMAX_EN
  logic signed [PW-1:0] rmin_p2, rmax_p2, rmin_nxt_p1, rmax_nxt_p1;

  always_comb begin
    rmin_nxt_p1 = first_p1 ? '0 : ((rel_p1 < rmin_p2) ? rel_p1 : rmin_p2);
    rmax_nxt_p1 = first_p1 ? '0 : ((rel_p1 > rmax_p2) ? rel_p1 : rmax_p2);
  end
`endif

  // Stage 2: window datapath and lock/fault control
  always_ff @(posedge rclk) begin
    if (vld_p1 && !err_p1) begin
      ph_prev_p2 <= ph_p1;
      base_p2    <= base_nxt_p1;
      sum_p2     <= sum_nxt_p1;
`ifdef PHDIFF_MINMAX_EN
      rmin_p2    <= rmin_nxt_p1;
      rmax_p2    <= rmax_nxt_p1;
`endif
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_p2     <= IDLE;
      qcnt_p2      <= '0;
      prev_ok_p2   <= 1'b0;
      win_cnt_p2   <= '0;
      locked       <= 1'b0;
      fault_sticky <= 1'b0;
      slips        <= '0;
      avg_valid    <= 1'b0;
      avg_out      <= '0;
      vfreq_hold   <= '0;
`ifdef PHDIFF_MINMAX_EN
      ph_min       <= '0;
      ph_max       <= '0;
`endif
    end else begin
      avg_valid    <= 1'b0;
      fault_sticky <= fault_p1 | (fault_sticky & ~clear);
      slips        <= slip_p1 ? sat_inc(clear ? '0 : slips) : (clear ? '0 : slips);
      if (vld_p1) begin
        if (err_p1) begin
          state_p2   <= FAULT;
          locked     <= 1'b0;
          qcnt_p2    <= '0;
          prev_ok_p2 <= 1'b0;
          win_cnt_p2 <= '0;
        end else begin
          prev_ok_p2 <= 1'b1;
          win_cnt_p2 <= win_cnt_p2 + avg_log'(1);
          if (last_p1) begin
            avg_valid  <= 1'b1;
            avg_out    <= avg_nxt_p1;
            vfreq_hold <= vf_p1;
`ifdef PHDIFF_MINMAX_EN
            ph_min     <= base_nxt_p1 + rmin_nxt_p1;
            ph_max     <= base_nxt_p1 + rmax_nxt_p1;
`endif
          end
          case (state_p2)
            IDLE, FAULT: begin
              state_p2 <= ACQUIRE;
              qcnt_p2  <= '0;
              locked   <= 1'b0;
            end
            ACQUIRE: begin
              if (!quiet_p1) begin
                qcnt_p2 <= '0;
              end else if (qcnt_p2 == QW'(lock_n - 1)) begin
                state_p2 <= LOCKED;
                locked   <= 1'b1;
                qcnt_p2  <= '0;
              end else begin
                qcnt_p2 <= qcnt_p2 + QW'(1);
              end
            end
            LOCKED: begin
              if (!quiet_p1) begin
                state_p2 <= ACQUIRE;
                locked   <= 1'b0;
                qcnt_p2  <= '0;
              end
            end
            default: state_p2 <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
